// File: rtl/bin_to_bcd_stream.sv
// rtl/bin_to_bcd_stream.sv - handshaked shift-and-add-3 binary to packed BCD converter
// Optional two's complement input with sign output when BIN2BCD_SIGNED_EN is defined.
module bin_to_bcd_stream #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_overflow
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                  out_sign
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     bin;
    logic [4*DIGITS-1:0]  bcd;
    logic                 ovf;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mag;
    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  bcd_next;
    logic [WIDTH-1:0]     bin_next;
    logic                 carry;
`ifdef BIN2BCD_SIGNED_EN
    logic                 sign_q;
`endif

    assign in_ready = (state == IDLE);

`ifdef BIN2BCD_SIGNED_EN
    // Negating the most negative value wraps to itself, which reads correctly as unsigned.
    assign mag = in_data[WIDTH-1] ? ((~in_data) + WIDTH'(1)) : in_data;
`else
    assign mag = in_data;
`endif

    always_comb begin
        adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] > 4'd4) begin
                adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    assign carry    = adj[4*DIGITS-1];
    assign bcd_next = {adj[4*DIGITS-2:0], bin[WIDTH-1]};
    assign bin_next = {bin[WIDTH-2:0], 1'b0};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bin          <= '0;
            bcd          <= '0;
            ovf          <= 1'b0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_bcd      <= '0;
            out_overflow <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q       <= 1'b0;
            out_sign     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin   <= mag;
                        bcd   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
                        sign_q <= in_data[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    // After the last shift step, one cycle publishes the result.
                    if (cnt == LAST) begin
                        out_bcd      <= bcd;
                        out_overflow <= ovf;
                        out_valid    <= 1'b1;
                        state        <= DONE;
`ifdef BIN2BCD_SIGNED_EN
                        out_sign     <= sign_q;
`endif
                    end else begin
                        bcd <= bcd_next;
                        bin <= bin_next;
                        ovf <= ovf | carry;
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
